sram_result_checker: RTL and testbench
======================================

Name: sram_result_checker

Overview:
- Read-side result checker for the SRAM test path. It sits between the address/pattern generators, the SRAM read data bus and the test controller.
- Each enabled cycle, it queues the generated address and expected pattern word through a delay line matching the SRAM read latency. It then compares the returned data against the expected word.
- It raises a sticky test_fail to the controller and captures first-failure diagnostics for the debug/UART path.

Parameters:
- ADDR_BITS, 20: width of the SRAM address.
- DATA_BITS, 16: width of the SRAM data word.
- READ_LATENCY, 2: clock edges from address issue to valid sram_data. Legal range 1..8.
- COUNT_BITS, 16: width of the error and check counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of all state. Pulsed by the controller at the start of a test run.
- enable  input  1  a read is being issued this cycle (controller READING state).
- addr  input  ADDR_BITS  address issued to SRAM this cycle.
- expected  input  DATA_BITS  pattern word expected at addr.
- sram_data  input  DATA_BITS  data returned by the SRAM.
- busy  output  1  one or more compares are still in flight.
- test_fail  output  1  sticky mismatch flag.
- fail_addr  output  ADDR_BITS  address of the first mismatch.
- fail_expected  output  DATA_BITS  expected word at the first mismatch.
- fail_actual  output  DATA_BITS  data read at the first mismatch.
- error_count  output  COUNT_BITS  total mismatches, saturating.
- check_count  output  COUNT_BITS  total compares performed, saturating.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0.
  - All pipeline valid bits go to 0.
  - Pipeline address/data contents are don't-care.
- Delay line:
  - READ_LATENCY stages, each holding {valid, addr, expected}.
  - Stage 0 loads {enable, addr, expected} on every rising edge. It loads even when enable=0, so valid=0 propagates.
  - Each stage shifts to the next stage every edge. There is no stall and no backpressure.
- Compare timing:
  - An entry accepted at edge T (enable=1 sampled) is compared against sram_data sampled at edge T+READ_LATENCY.
  - Results (test_fail, counters, capture registers) are visible immediately after that edge.
  - Example with READ_LATENCY=2: enable at edge 0 → test_fail can rise after edge 2.
- On a compare edge with a valid entry:
  - check_count increments.
  - On mismatch:
    - error_count increments.
    - test_fail is set.
    - If test_fail was 0 before this edge, fail_addr/fail_expected/fail_actual load the entry's addr, the entry's expected and sram_data.
  - Later mismatches never overwrite the capture registers.
- Counters:
  - Saturate at all-ones and never wrap.
  - Saturation of check_count does not stop mismatch detection.
- test_fail: sticky. Cleared only by reset or clear.
- busy: OR of all pipeline valid bits.
- Drain: enable dropping does not cancel in-flight entries. They are still compared on their scheduled edges.
  - The controller must wait for busy=0 before treating a pass as final.
- clear:
  - Synchronous, with priority over enable and over any compare on the same edge.
  - Zeros counters, test_fail, capture registers and all valid bits. In-flight entries are discarded.
  - enable on the same edge as clear is ignored.
- Reset mid-run: same effect as clear, but asynchronous.
- Comparison: full DATA_BITS equality, no masking.
- Back-to-back enables: one compare per cycle at full throughput.
- Multiple consecutive mismatches: the capture registers hold only the first; error_count counts all of them.
- READ_LATENCY=1: a single stage, compare on the next edge.

Test Plan:
1. Defaults. Enable 4 cycles, addr 0..3, expected 16'hA5A5, SRAM returns 16'hA5A5 two edges later. → test_fail=0, check_count=4, error_count=0, busy=0 after edge 6.
2. Defaults. Addr 0..3 expected 16'h00FF; SRAM returns 16'h00FE for addr 2 only. → test_fail rises after the edge carrying addr 2's compare; fail_addr=2, fail_expected=16'h00FF, fail_actual=16'h00FE, error_count=1, check_count=4.
3. Mismatches at addr 5 (data 16'h1111 vs expected 16'h0000) and addr 9 (16'h2222 vs 16'h0000). → capture holds addr 5 / 16'h0000 / 16'h1111; error_count=2.
4. Enable for 3 cycles, then drop enable; the last entry mismatches. → busy=1 for 2 cycles after enable drops; test_fail still sets; busy=0 afterwards.
5. Fail state present, then assert clear on the same cycle as enable and a pending mismatching compare. → all outputs 0 after the edge; no compare from the pending entry ever counted.
6. COUNT_BITS=4. Run 20 mismatching compares. → error_count=check_count=4'hF, held at 4'hF; test_fail=1. Assert reset mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sram_result_checker.sv
// sram_result_checker
//
// Read-side result checker for the SRAM test path. Each cycle the issued
// address and expected pattern word are pushed into a delay line that
// matches the SRAM read latency; when an entry reaches the end of the line
// it is compared against the data the SRAM returns on that edge. A sticky
// test_fail flag, saturating error/check counters and first-failure
// diagnostics (address, expected word, actual word) are produced.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   clear         synchronous clear of all state (priority over everything)
//   enable        a read is being issued this cycle
//   addr          address issued to the SRAM this cycle
//   expected      pattern word expected at addr
//   sram_data     data returned by the SRAM
//   busy          one or more compares still in flight
//   test_fail     sticky mismatch flag
//   fail_addr     address of the first mismatch
//   fail_expected expected word at the first mismatch
//   fail_actual   data read at the first mismatch
//   error_count   total mismatches, saturating
//   check_count   total compares performed, saturating
//
// READ_LATENCY must lie in 1..8.

module sram_result_checker #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int READ_LATENCY = 2,
    parameter int COUNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_BITS-1:0]  expected,
    input  logic [DATA_BITS-1:0]  sram_data,
    output logic                  busy,
    output logic                  test_fail,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_BITS-1:0]  fail_expected,
    output logic [DATA_BITS-1:0]  fail_actual,
    output logic [COUNT_BITS-1:0] error_count,
    output logic [COUNT_BITS-1:0] check_count
);

    localparam int                  LAST      = READ_LATENCY - 1;
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);

    // ------------------------------------------------------------------
    // Delay line: stage 0 takes the current request, every other stage
    // takes its predecessor. Only the valid bits need a reset; the
    // address/expected payload is ignored whenever valid is low.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] valid_d;
    logic [ADDR_BITS-1:0]    addr_q [READ_LATENCY];
    logic [ADDR_BITS-1:0]    addr_d [READ_LATENCY];
    logic [DATA_BITS-1:0]    exp_q  [READ_LATENCY];
    logic [DATA_BITS-1:0]    exp_d  [READ_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // A request on the same edge as clear is dropped.
                assign valid_d[gi] = enable & ~clear;
                assign addr_d[gi]  = addr;
                assign exp_d[gi]   = expected;
            end else begin : g_tail
                // clear discards everything already in flight.
                assign valid_d[gi] = valid_q[gi-1] & ~clear;
                assign addr_d[gi]  = addr_q[gi-1];
                assign exp_d[gi]   = exp_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        exp_q  <= exp_d;
    end

    // ------------------------------------------------------------------
    // Compare stage: the entry in the last stage meets the SRAM data
    // sampled on this edge.
    // ------------------------------------------------------------------
    logic cmp_valid;
    logic cmp_mismatch;

    assign cmp_valid    = valid_q[LAST];
    assign cmp_mismatch = cmp_valid && (sram_data != exp_q[LAST]);

    logic                  test_fail_q,     test_fail_d;
    logic [ADDR_BITS-1:0]  fail_addr_q,     fail_addr_d;
    logic [DATA_BITS-1:0]  fail_expected_q, fail_expected_d;
    logic [DATA_BITS-1:0]  fail_actual_q,   fail_actual_d;
    logic [COUNT_BITS-1:0] error_count_q,   error_count_d;
    logic [COUNT_BITS-1:0] check_count_q,   check_count_d;

    always_comb begin
        test_fail_d     = test_fail_q;
        fail_addr_d     = fail_addr_q;
        fail_expected_d = fail_expected_q;
        fail_actual_d   = fail_actual_q;
        error_count_d   = error_count_q;
        check_count_d   = check_count_q;

        if (clear) begin
            test_fail_d     = 1'b0;
            fail_addr_d     = '0;
            fail_expected_d = '0;
            fail_actual_d   = '0;
            error_count_d   = '0;
            check_count_d   = '0;
        end else if (cmp_valid) begin
            if (check_count_q != COUNT_MAX) begin
                check_count_d = check_count_q + COUNT_ONE;
            end
            if (cmp_mismatch) begin
                if (error_count_q != COUNT_MAX) begin
                    error_count_d = error_count_q + COUNT_ONE;
                end
                test_fail_d = 1'b1;
                // Diagnostics describe only the first failure of a run.
                if (!test_fail_q) begin
                    fail_addr_d     = addr_q[LAST];
                    fail_expected_d = exp_q[LAST];
                    fail_actual_d   = sram_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            test_fail_q     <= 1'b0;
            fail_addr_q     <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
            error_count_q   <= '0;
            check_count_q   <= '0;
        end else begin
            test_fail_q     <= test_fail_d;
            fail_addr_q     <= fail_addr_d;
            fail_expected_q <= fail_expected_d;
            fail_actual_q   <= fail_actual_d;
            error_count_q   <= error_count_d;
            check_count_q   <= check_count_d;
        end
    end

    assign busy          = |valid_q;
    assign test_fail     = test_fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_expected_q;
    assign fail_actual   = fail_actual_q;
    assign error_count   = error_count_q;
    assign check_count   = check_count_q;

endmodule

// File: tb/tb_sram_result_checker.sv
// Bench for sram_result_checker. Three instances share the request stream:
//   u0: READ_LATENCY=2, COUNT_BITS=16 (defaults)
//   u1: READ_LATENCY=1, COUNT_BITS=16
//   u2: READ_LATENCY=2, COUNT_BITS=4
// Each instance gets its own SRAM return data. The reference model keeps a
// per-cycle log of issued requests; an instance with latency L compares the
// request logged L cycles earlier, unless a clear/reset wiped it.

module tb_sram_result_checker;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int NI   = 3;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          enable;
    logic [AW-1:0] addr;
    logic [DW-1:0] expected;
    logic [DW-1:0] sr [NI];

    logic [NI-1:0] busy_w;
    logic [NI-1:0] fail_w;
    logic [AW-1:0] fa0, fa1, fa2;
    logic [DW-1:0] fe0, fe1, fe2;
    logic [DW-1:0] fx0, fx1, fx2;
    logic [15:0]   er0, er1, ck0, ck1;
    logic [3:0]    er2, ck2;

    always #5 clk = ~clk;

    sram_result_checker #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(2), .COUNT_BITS(16)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .addr(addr),
        .expected(expected), .sram_data(sr[0]), .busy(busy_w[0]), .test_fail(fail_w[0]),
        .fail_addr(fa0), .fail_expected(fe0), .fail_actual(fx0),
        .error_count(er0), .check_count(ck0));

    sram_result_checker #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(1), .COUNT_BITS(16)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .addr(addr),
        .expected(expected), .sram_data(sr[1]), .busy(busy_w[1]), .test_fail(fail_w[1]),
        .fail_addr(fa1), .fail_expected(fe1), .fail_actual(fx1),
        .error_count(er1), .check_count(ck1));

    sram_result_checker #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(2), .COUNT_BITS(4)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .addr(addr),
        .expected(expected), .sram_data(sr[2]), .busy(busy_w[2]), .test_fail(fail_w[2]),
        .fail_addr(fa2), .fail_expected(fe2), .fail_actual(fx2),
        .error_count(er2), .check_count(ck2));

    // ---------------- reference model ----------------
    int            lat  [NI] = '{2, 1, 2};
    int            cmax [NI] = '{65535, 65535, 15};
    int            cyc;
    logic [DW-1:0] cur_ret;

    bit            ent_v [MAXC];
    logic [AW-1:0] ent_a [MAXC];
    logic [DW-1:0] ent_e [MAXC];
    logic [DW-1:0] ent_r [MAXC];

    bit            m_fail [NI];
    logic [AW-1:0] m_fa   [NI];
    logic [DW-1:0] m_fe   [NI];
    logic [DW-1:0] m_fx   [NI];
    int            m_err  [NI];
    int            m_chk  [NI];

    int total;
    int bad;

    task automatic model_wipe();
        for (int k = 0; k < NI; k++) begin
            m_fail[k] = 1'b0; m_fa[k] = '0; m_fe[k] = '0; m_fx[k] = '0;
            m_err[k]  = 0;    m_chk[k] = 0;
        end
        for (int j = cyc - 8; j <= cyc; j++) begin
            if (j >= 0) ent_v[j] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (clear) begin
            model_wipe();
        end else begin
            ent_v[cyc] = enable;
            ent_a[cyc] = addr;
            ent_e[cyc] = expected;
            ent_r[cyc] = cur_ret;
            for (int k = 0; k < NI; k++) begin
                int j = cyc - lat[k];
                if (j >= 0 && ent_v[j]) begin
                    if (m_chk[k] < cmax[k]) m_chk[k]++;
                    if (ent_e[j] != sr[k]) begin
                        if (m_err[k] < cmax[k]) m_err[k]++;
                        if (!m_fail[k]) begin
                            m_fa[k] = ent_a[j]; m_fe[k] = ent_e[j]; m_fx[k] = sr[k];
                        end
                        m_fail[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [85:0] m_bundle(int k);
        bit b = 1'b0;
        for (int j = cyc - lat[k]; j < cyc; j++) begin
            if (j >= 0 && ent_v[j]) b = 1'b1;
        end
        return {b, m_fail[k], m_fa[k], m_fe[k], m_fx[k], 16'(m_err[k]), 16'(m_chk[k])};
    endfunction

    function automatic logic [85:0] o_bundle(int k);
        case (k)
            0:       return {busy_w[0], fail_w[0], fa0, fe0, fx0, er0, ck0};
            1:       return {busy_w[1], fail_w[1], fa1, fe1, fx1, er1, ck1};
            default: return {busy_w[2], fail_w[2], fa2, fe2, fx2, 12'd0, er2, 12'd0, ck2};
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    // Drive each instance's SRAM return for the coming edge, clock once,
    // advance the model, then step to the sampling point 1ns after the edge.
    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            int j = cyc - lat[k];
            if (j >= 0 && ent_v[j]) sr[k] = ent_r[j];
            else                    sr[k] = DW'($urandom);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic [DW-1:0] r);
        clear = 1'b0; enable = 1'b1; addr = a; expected = e; cur_ret = r;
        tick();
    endtask

    task automatic idle(input int n);
        clear = 1'b0; enable = 1'b0; addr = AW'($urandom); expected = DW'($urandom);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; enable = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; enable = 1'b0; addr = '0; expected = '0; cur_ret = '0;
        for (int k = 0; k < NI; k++) sr[k] = '0;
        cyc = 0;
        model_wipe();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== 86'd0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got=%h want=0", k, o_bundle(k));
            end
            $display("reset check inst=%0d bundle=%h", k, o_bundle(k));
        end
    endtask

    task automatic test_all_match();
        for (int i = 0; i < 4; i++) issue(AW'(i), 16'hA5A5, 16'hA5A5);
        idle(1);
        total++;
        if (busy_w[0] !== 1'b1) begin
            bad++; $display("FAIL match_busy_drain got=%b want=1", busy_w[0]);
        end
        idle(2);
        total++;
        if ({busy_w[0], fail_w[0], er0, ck0} !== {1'b0, 1'b0, 16'd0, 16'd4}) begin
            bad++;
            $display("FAIL match_final busy=%b fail=%b err=%0d chk=%0d want 0/0/0/4", busy_w[0], fail_w[0], er0, ck0);
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL match_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("all_match: chk=%0d err=%0d fail=%b", ck0, er0, fail_w[0]);
    endtask

    task automatic test_single_mismatch();
        do_clear();
        for (int i = 0; i < 4; i++) issue(AW'(i), 16'h00FF, (i == 2) ? 16'h00FE : 16'h00FF);
        total++;
        if (fail_w[0] !== 1'b0) begin
            bad++; $display("FAIL single_early got=%b want=0", fail_w[0]);
        end
        idle(1);
        total++;
        if (fail_w[0] !== 1'b1) begin
            bad++; $display("FAIL single_rise got=%b want=1", fail_w[0]);
        end
        idle(2);
        total++;
        if ({fa0, fe0, fx0, er0, ck0} !== {20'd2, 16'h00FF, 16'h00FE, 16'd1, 16'd4}) begin
            bad++;
            $display("FAIL single_capture addr=%h exp=%h act=%h err=%0d chk=%0d want 2/00ff/00fe/1/4", fa0, fe0, fx0, er0, ck0);
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL single_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("single_mismatch: addr=%h exp=%h act=%h err=%0d", fa0, fe0, fx0, er0);
    endtask

    task automatic test_first_capture();
        do_clear();
        for (int i = 0; i < 12; i++) begin
            issue(AW'(i), 16'h0000, (i == 5) ? 16'h1111 : ((i == 9) ? 16'h2222 : 16'h0000));
        end
        idle(3);
        total++;
        if ({fail_w[0], fa0, fe0, fx0, er0, ck0} !== {1'b1, 20'd5, 16'h0000, 16'h1111, 16'd2, 16'd12}) begin
            bad++;
            $display("FAIL first_capture addr=%h exp=%h act=%h err=%0d chk=%0d want 5/0000/1111/2/12", fa0, fe0, fx0, er0, ck0);
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL first_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("first_capture: addr=%h act=%h err=%0d", fa0, fx0, er0);
    endtask

    task automatic test_drain();
        do_clear();
        issue(20'h00100, 16'h1234, 16'h1234);
        issue(20'h00101, 16'h1234, 16'h1234);
        issue(20'h00102, 16'h1234, 16'h4321);
        enable = 1'b0;
        total++;
        if (busy_w[0] !== 1'b1) begin
            bad++; $display("FAIL drain_busy1 got=%b want=1", busy_w[0]);
        end
        idle(1);
        total++;
        if ({busy_w[0], fail_w[0]} !== 2'b10) begin
            bad++; $display("FAIL drain_busy2 busy=%b fail=%b want 1/0", busy_w[0], fail_w[0]);
        end
        idle(1);
        total++;
        if ({busy_w[0], fail_w[0], fa0} !== {2'b01, 20'h00102}) begin
            bad++; $display("FAIL drain_done busy=%b fail=%b addr=%h want 0/1/00102", busy_w[0], fail_w[0], fa0);
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL drain_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("drain: busy=%b fail=%b addr=%h", busy_w[0], fail_w[0], fa0);
    endtask

    task automatic test_clear_priority();
        do_clear();
        issue(20'h7, 16'hAAAA, 16'h5555);
        idle(2);
        total++;
        if (fail_w[0] !== 1'b1) begin
            bad++; $display("FAIL clear_setup got=%b want=1", fail_w[0]);
        end
        issue(20'h8, 16'hBBBB, 16'h0000);
        idle(1);
        // Clear, a new request and the pending compare all land on this edge.
        clear = 1'b1; enable = 1'b1; addr = 20'h9; expected = 16'hCCCC; cur_ret = 16'h0;
        tick();
        clear = 1'b0;
        total++;
        if (o_bundle(0) !== 86'd0) begin
            bad++; $display("FAIL clear_edge got=%h want=0", o_bundle(0));
        end
        idle(3);
        total++;
        if (o_bundle(0) !== 86'd0) begin
            bad++; $display("FAIL clear_after got=%h want=0", o_bundle(0));
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL clear_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("clear_priority: bundle=%h", o_bundle(0));
    endtask

    task automatic test_saturation();
        logic [DW-1:0] e;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            e = DW'($urandom);
            issue(AW'(i + 32), e, e ^ 16'h0001);
        end
        idle(2);
        total++;
        if ({er2, ck2, fail_w[2]} !== {4'hF, 4'hF, 1'b1}) begin
            bad++; $display("FAIL sat_small err=%h chk=%h fail=%b want f/f/1", er2, ck2, fail_w[2]);
        end
        total++;
        if ({er0, ck0} !== {16'd20, 16'd20}) begin
            bad++; $display("FAIL sat_wide err=%0d chk=%0d want 20/20", er0, ck0);
        end
        issue(20'h40, 16'h0F0F, 16'h0F0E);
        issue(20'h41, 16'h0F0F, 16'h0F0E);
        // Asynchronous reset between edges with compares still in flight.
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== 86'd0) begin
                bad++; $display("FAIL async_reset inst=%0d got=%h want=0", k, o_bundle(k));
            end
        end
        #1 reset = 1'b0;
        model_wipe();
        issue(20'h50, 16'h1357, 16'h1356);
        idle(3);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL sat_model inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("saturation: small err=%h chk=%h after-reset err=%0d", er2, ck2, er0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            e        = DW'($urandom);
            clear    = ($urandom_range(31) == 0);
            enable   = ($urandom_range(3) != 0);
            addr     = AW'($urandom);
            expected = e;
            cur_ret  = ($urandom_range(7) == 0) ? (e ^ (DW'(1) << $urandom_range(DW - 1))) : e;
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if (o_bundle(k) !== m_bundle(k)) begin
                    bad++;
                    $display("FAIL random_cycle i=%0d inst=%0d got=%h want=%h", i, k, o_bundle(k), m_bundle(k));
                end
            end
        end
        idle(4);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (o_bundle(k) !== m_bundle(k)) begin
                bad++; $display("FAIL random_final inst=%0d got=%h want=%h", k, o_bundle(k), m_bundle(k));
            end
        end
        $display("back_to_back: chk=%0d err=%0d fail=%b", ck0, er0, fail_w[0]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_match();
        test_single_mismatch();
        test_first_capture();
        test_drain();
        test_clear_priority();
        test_saturation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
